sample_pattern_gen: RTL
=======================

Name: sample_pattern_gen

Overview:
- Paced test-sample source that drives the input side of the filter and delay blocks (e.g. delayw i_data) with deterministic patterns.
- Board tops use it instead of a constant input: it produces impulse/step/ramp/square/pseudo-random 8-bit samples at a programmable rate.
- Samples are offered on a valid/ready handshake; DSP blocks without backpressure tie i_ready high.
- Includes start/stop control, an accepted-sample counter and a sticky overrun flag for on-board debug via LEDs.

Parameters:
DATA_W, 8, sample width; the LFSR mode uses bits [7:0] and zero-extends above.
DIV_W, 16, width of the rate divider.
SQ_HALF, 8, samples per half-period in square mode; must be ≥1.
CNT_W, 16, width of the accepted-sample counter.

Ports:
i_clk  in  1  system clock; single clock domain.
i_reset_n  in  1  synchronous, active-low reset.
i_start  in  1  pulse; starts generation when IDLE.
i_stop  in  1  pulse; ends generation when RUN.
i_mode  in  3  pattern select: 0 zero, 1 impulse, 2 step, 3 ramp, 4 square, 5 LFSR, 6–7 zero.
i_amp  in  DATA_W  amplitude for impulse/step/square.
i_div  in  DIV_W  sample period minus 1, in clocks.
o_data  out  DATA_W  current sample.
o_valid  out  1  sample offered.
i_ready  in  1  consumer accepts when high together with o_valid.
o_busy  out  1  high when state != IDLE.
o_overrun  out  1  sticky; a tick was lost because the previous sample was still pending.
o_sample_cnt  out  CNT_W  number of accepted transfers; wraps.

Behaviour:
- Reset (i_reset_n low at edge), applies in every state, including mid-transfer:
  - state IDLE; o_valid 0; o_data 0; o_overrun 0; o_sample_cnt 0; prescaler 0; sample index 0; LFSR 0x01.
- FSM states:
  - IDLE: i_start high at edge k → RUN. Same edge latches i_mode/i_amp/i_div, clears prescaler, index, o_sample_cnt and o_overrun, and seeds LFSR to 0x01. i_stop is ignored.
  - RUN: i_stop high → DRAIN if o_valid is pending after this edge, else IDLE. i_start is ignored. If i_start and i_stop are both high, stop wins. Config inputs are not re-sampled.
  - DRAIN: no new ticks. Go to IDLE at the edge where the pending transfer completes.
- Tick generation:
  - In RUN, tick when prescaler==0; prescaler then reloads the latched div, otherwise it decrements.
  - First tick is at edge k+1, then every div+1 clocks. div=0 gives a tick every clock.
- On a tick, if o_valid is low or a transfer completes at this edge:
  - o_valid is set to 1, o_data is loaded with the next sample, and the index increments.
- On a tick with o_valid high and i_ready low:
  - sample is held, o_overrun is set, and the pattern does not advance.
- Handshake:
  - transfer happens when o_valid && i_ready at an edge.
  - o_data and o_valid stay stable while o_valid && !i_ready.
  - After a transfer with no simultaneous tick, o_valid drops to 0.
  - o_sample_cnt increments on every transfer.
- Patterns, with n = sample index from 0:
  - zero: 0.
  - impulse: amp at n=0, else 0.
  - step: amp.
  - ramp: n mod 2^DATA_W.
  - square: amp when (n / SQ_HALF) is even, else 0.
  - LFSR: output the current state, then advance as a Galois shift right; if the old LSB was 1, XOR 0xB8. Sequence is 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3, …, period 255.
- Latency: i_start at edge k → first o_valid at edge k+1.

Test Plan:
- Reset mid-RUN with o_valid high → next cycle o_valid=0, o_data=0, o_busy=0, o_sample_cnt=0; no further samples without a new start.
- mode=3, div=3, i_ready=1, start at edge k → o_valid one-cycle pulses at k+1, k+5, k+9 carrying 0, 1, 2. After 300 samples, data wraps 255→0 and o_sample_cnt=300.
- mode=4, amp=0x7F, div=0, SQ_HALF=8, i_ready=1 → o_valid continuously high; data 8×0x7F, 8×0x00, repeating.
- mode=5, div=0, i_ready=1 → first six samples 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3; sample 256 equals sample 1 (0x01).
- mode=1, amp=0x40, div=2, i_ready low for 7 clocks after the first valid → o_data held at 0x40, o_overrun=1. After ready rises, the next sample is 0x00 and o_sample_cnt counts only transfers.
- mode=2, i_stop asserted while o_valid high and i_ready=0 → DRAIN with o_busy=1. Raising i_ready → one transfer, then IDLE with o_busy=0. i_start and i_stop in the same cycle during RUN → stop.

Source files
------------

// File: rtl/sample_pattern_gen.sv
// Paced deterministic sample source (zero/impulse/step/ramp/square/LFSR) offered on a
// valid/ready handshake, with start/stop control, a transfer counter and a sticky overrun flag.
module sample_pattern_gen #(
    parameter int DATA_W  = 8,
    parameter int DIV_W   = 16,
    parameter int SQ_HALF = 8,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [2:0]        i_mode,
    input  logic [DATA_W-1:0] i_amp,
    input  logic [DIV_W-1:0]  i_div,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_overrun,
    output logic [CNT_W-1:0]  o_sample_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [2:0]         mode_q;
    logic [DATA_W-1:0]  amp_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   presc;
    logic [DATA_W-1:0]  idx;
    logic               first_q;
    logic [15:0]        sq_cnt;
    logic               sq_phase;
    logic [7:0]         lfsr;

    logic tick;
    logic xfer;
    logic load;
    logic valid_nxt;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    // The impulse uses first_q and the square uses a phase bit so neither depends on idx wrapping.
    function automatic logic [DATA_W-1:0] pattern(
        input logic [2:0]        mode,
        input logic [DATA_W-1:0] amp,
        input logic [DATA_W-1:0] n,
        input logic              first,
        input logic              phase,
        input logic [7:0]        lfsr_s
    );
        logic [DATA_W-1:0] v;
        v = '0;
        case (mode)
            3'd1:    v = first ? amp : '0;
            3'd2:    v = amp;
            3'd3:    v = n;
            3'd4:    v = phase ? '0 : amp;
            3'd5:    v = DATA_W'(lfsr_s);
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        tick      = (state == RUN) && (presc == '0);
        xfer      = o_valid && i_ready;
        load      = tick && (!o_valid || i_ready);
        valid_nxt = load || (o_valid && !i_ready);
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_overrun    <= 1'b0;
            o_sample_cnt <= '0;
            presc        <= '0;
            idx          <= '0;
            first_q      <= 1'b1;
            sq_cnt       <= '0;
            sq_phase     <= 1'b0;
            lfsr         <= 8'h01;
            mode_q       <= '0;
            amp_q        <= '0;
            div_q        <= '0;
        end else begin
            if (xfer) begin
                o_sample_cnt <= o_sample_cnt + CNT_W'(1);
            end

            if (load) begin
                o_valid <= 1'b1;
                o_data  <= pattern(mode_q, amp_q, idx, first_q, sq_phase, lfsr);
                idx     <= idx + DATA_W'(1);
                first_q <= 1'b0;
                lfsr    <= lfsr_step(lfsr);
                if (sq_cnt == 16'(SQ_HALF - 1)) begin
                    sq_cnt   <= '0;
                    sq_phase <= ~sq_phase;
                end else begin
                    sq_cnt <= sq_cnt + 16'd1;
                end
            end else if (xfer) begin
                o_valid <= 1'b0;
            end

            // A tick that finds the previous sample still unaccepted is dropped.
            if (tick && o_valid && !i_ready) begin
                o_overrun <= 1'b1;
            end

            if (state == RUN) begin
                presc <= tick ? div_q : presc - DIV_W'(1);
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state        <= RUN;
                        mode_q       <= i_mode;
                        amp_q        <= i_amp;
                        div_q        <= i_div;
                        presc        <= '0;
                        idx          <= '0;
                        first_q      <= 1'b1;
                        sq_cnt       <= '0;
                        sq_phase     <= 1'b0;
                        lfsr         <= 8'h01;
                        o_sample_cnt <= '0;
                        o_overrun    <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        state <= valid_nxt ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
